crc16_frame_appender: RTL and testbench
=======================================

// Module: crc16_frame_appender
// PURPOSE
//  Downstream framing stage for the CRC-16 datapath. Takes a byte stream framed by
//  s_last, forwards every payload byte unchanged and updates a running CRC-16 over
//  it. After the last payload byte it appends the 2-byte CRC (high byte first) and
//  then re-arms for the next frame. Valid/ready handshake on both sides.
// PARAMETERS
//  POLY    16'h1021  generator polynomial, MSB-first, non-reflected
//  INIT    16'hFFFF  CRC register value at start of every frame
//  XOROUT  16'h0000  XORed into the CRC before it is appended / reported
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-high
//  s_data     in   8   payload byte
//  s_valid    in   1   s_data/s_last valid
//  s_last     in   1   final payload byte of frame (qualified by s_valid)
//  s_ready    out  1   appender accepts s_data this cycle
//  m_data     out  8   output byte (payload, then CRC[15:8], then CRC[7:0])
//  m_valid    out  1   m_data/m_last valid
//  m_last     out  1   asserted with CRC[7:0] byte only
//  m_ready    in   1   downstream accepts m_data this cycle
//  crc_out    out  16  final CRC of the most recently completed frame (post-XOROUT)
//  crc_done   out  1   1-cycle pulse: CRC low byte handshaked; crc_out updated same edge
// BEHAVIOUR
//  - Handshake: s_fire = s_valid & s_ready; m_fire = m_valid & m_ready.
//    m_valid/m_data/m_last never change while m_valid=1 & m_ready=0.
//  - Output is a single registered stage: free = !m_valid | m_ready.
//  - FSM states: PAYLOAD, CRC_HI, CRC_LO.
//    PAYLOAD: s_ready = free. On s_fire: m_data<=s_data, m_valid<=1, m_last<=0,
//      crc<=upd(crc,s_data). If s_last also: -> CRC_HI. If free & !s_valid: m_valid<=0.
//    CRC_HI: s_ready=0. When free: m_data<=crc_x[15:8], m_valid<=1, m_last<=0 -> CRC_LO.
//    CRC_LO: s_ready=0. When free: m_data<=crc_x[7:0], m_valid<=1, m_last<=1;
//      crc<=INIT -> PAYLOAD.
//    crc_x = crc ^ XOROUT.
//  - crc_out/crc_done: on m_fire of the byte with m_last=1, crc_out<=that frame's
//    crc_x and crc_done<=1 for one cycle; otherwise crc_done<=0. crc_out holds.
//  - upd(c,d): 8 serial steps, MSB of d first:
//      fb = c[15]^d[7-i]; c = {c[14:0],1'b0} ^ (fb ? POLY : 0).
//    Unrolled combinationally. Single cycle, no extra latency.
//  - Latency: payload byte appears on m_data 1 cycle after s_fire.
//    With m_ready=1 throughout, an N-byte frame occupies N+2 consecutive m_valid
//    cycles. s_ready is low for exactly 2 cycles after s_last is accepted.
//  - Every frame carries >=1 payload byte (s_last is only seen with a byte).
//    Zero-length frames do not exist.
//  - s_last on the first byte is legal: 1-byte payload + 2 CRC bytes.
//  - Back-to-back frames: next frame's first byte is accepted the cycle CRC_LO
//    loads its byte, provided free. crc restarts from INIT for it.
//  - Reset (any state, incl. mid-frame or mid-CRC): state<=PAYLOAD, crc<=INIT,
//    m_valid<=0, m_last<=0, m_data<=0, crc_out<=0, crc_done<=0.
//    The partial frame is discarded and nothing is appended for it.
//    s_ready is 1 in the first cycle after reset.
// TESTING
//  1. "123456789" (0x31..0x39, last on 0x39), m_ready=1 -> m_data = 9 payload bytes,
//     then 0x29, 0xB1 with m_last=1; crc_out=16'h29B1, crc_done pulses once.
//  2. Same frame, m_ready toggling 1/0 each cycle -> identical byte sequence; m_data
//     stable while stalled; crc_done coincides with the m_fire of 0xB1.
//  3. Two back-to-back frames, identical to test 1's frame -> 22 output bytes; both
//     CRC pairs 0x29,0xB1 (proves re-init to INIT).
//  4. Single-byte frame, m_ready=1 -> s_ready low exactly 2 cycles after accept;
//     3 output bytes; m_last only on the 3rd.
//  5. rst=1 for one cycle after the 5th byte of a frame, then send test 1's frame
//     -> no CRC emitted for the aborted frame; next frame yields 0x29,0xB1.
//  6. XOROUT=16'hFFFF build, test 1 stimulus -> appended 0xD6,0x4E; crc_out=16'hD64E.

Source files
------------

// File: rtl/crc16_frame_appender.sv
// crc16_frame_appender
// Framing stage: forwards payload bytes unchanged while accumulating a
// CRC-16 over them, then appends the CRC (high byte first) after the byte
// marked s_last. A single registered output stage carries all bytes.
// crc_out/crc_done report the CRC of the most recently delivered frame.

module crc16_frame_appender #(
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'hFFFF,
  parameter logic [15:0] XOROUT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [15:0] crc_out,
  output logic        crc_done
);

  typedef enum logic [1:0] {
    PAYLOAD = 2'd0,
    CRC_HI  = 2'd1,
    CRC_LO  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] crc;       // running CRC of the frame in progress
  logic [15:0] crc_hold;  // final CRC of the frame whose low byte is in flight
  logic [15:0] crc_x;
  logic [15:0] crc_next;
  logic        free;
  logic        s_fire;
  logic        m_fire;

  // One byte of MSB-first, non-reflected CRC, unrolled into combinational logic.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
    return r;
  endfunction

  // Handshake qualifiers and the next CRC value for the byte on s_data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    free     = 1'b0;
    s_ready  = 1'b0;
    s_fire   = 1'b0;
    m_fire   = 1'b0;
    crc_x    = crc ^ XOROUT;
    crc_next = crc_upd(crc, s_data);

    free    = !m_valid || m_ready;
    s_ready = (state == PAYLOAD) && free;
    s_fire  = s_valid && s_ready;
    m_fire  = m_valid && m_ready;
  end

  // Frame FSM: owns the output register, the running CRC and the held final CRC.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, so an aborted frame leaves no stale byte or CRC behind.
    if (rst) begin
      state    <= PAYLOAD;
      crc      <= INIT;
      crc_hold <= 16'h0000;
      m_data   <= 8'h00;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        PAYLOAD: begin
          if (s_fire) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            crc     <= crc_next;
            if (s_last) begin
              state <= CRC_HI;
            end
          end else if (free) begin
            // Output slot drained and nothing new offered.
            m_valid <= 1'b0;
            m_last  <= 1'b0;
          end
        end

        CRC_HI: begin
          if (free) begin
            m_data  <= crc_x[15:8];
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            state   <= CRC_LO;
          end
        end

        CRC_LO: begin
          if (free) begin
            m_data   <= crc_x[7:0];
            m_valid  <= 1'b1;
            m_last   <= 1'b1;
            crc_hold <= crc_x;
            crc      <= INIT;
            state    <= PAYLOAD;
          end
        end

        default: begin
          state   <= PAYLOAD;
          crc     <= INIT;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      endcase
    end
  end

  // Report the frame CRC when its final byte is accepted downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_out  <= 16'h0000;
      crc_done <= 1'b0;
    end else if (m_fire && m_last) begin
      crc_out  <= crc_hold;
      crc_done <= 1'b1;
    end else begin
      crc_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc16_frame_appender.sv
// tb_crc16_frame_appender
// Drives two appender instances (XOROUT = 0 and XOROUT = FFFF) with the same
// stimulus and checks them against a table-driven CRC model and a queue of
// expected output bytes.

module tb_crc16_frame_appender;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready, s_ready_x;
  logic [7:0]  m_data, m_data_x;
  logic        m_valid, m_valid_x;
  logic        m_last, m_last_x;
  logic        m_ready;
  logic [15:0] crc_out, crc_out_x;
  logic        crc_done, crc_done_x;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crc16_frame_appender u_dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .crc_out(crc_out), .crc_done(crc_done)
  );

  crc16_frame_appender #(.XOROUT(16'hFFFF)) u_dut_x (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready_x),
    .m_data(m_data_x), .m_valid(m_valid_x), .m_last(m_last_x), .m_ready(m_ready),
    .crc_out(crc_out_x), .crc_done(crc_done_x)
  );

  // ---------------- reference model ----------------
  int tbl [256];
  logic [9:0]  exp_q [$];   // {is_crc, last, data}
  logic [15:0] exp_crc [$]; // CRC (XOROUT = 0) of each completed frame
  int fires;
  int vcount;

  function automatic int model_crc(input logic [7:0] b [$]);
    int c;
    c = 'hFFFF;
    foreach (b[i]) c = ((c << 8) & 'hFFFF) ^ tbl[((c >> 8) ^ int'(b[i])) & 'hFF];
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- m_ready driver ----------------
  int rdy_mode = 0; // 0: always ready, 1: toggle, 2: random
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = ($urandom_range(99) < 65);
      endcase
    end
  end

  // ---------------- output monitor ----------------
  logic        prev_fire_last = 1'b0;
  logic        stalled = 1'b0;
  logic [7:0]  stall_data;
  logic        stall_last;

  always @(negedge clk) begin
    logic [9:0]  e;
    logic [15:0] ec;
    logic        fire;
    if (rst) begin
      prev_fire_last = 1'b0;
      stalled        = 1'b0;
    end else begin
      chk("m_valid_match", 32'(m_valid_x), 32'(m_valid));
      chk("crc_done", 32'(crc_done), 32'(prev_fire_last));
      chk("crc_done_x", 32'(crc_done_x), 32'(prev_fire_last));
      if (crc_done) begin
        if (exp_crc.size() > 0) begin
          ec = exp_crc.pop_front();
          chk("crc_out", 32'(crc_out), 32'(ec));
          chk("crc_out_x", 32'(crc_out_x), 32'(ec ^ 16'hFFFF));
        end else begin
          chk("crc_done_unexpected", 32'(crc_done), 32'(0));
        end
      end
      if (stalled) begin
        chk("stall_valid", 32'(m_valid), 32'(1));
        chk("stall_data", 32'(m_data), 32'(stall_data));
        chk("stall_last", 32'(m_last), 32'(stall_last));
      end
      if (m_valid) vcount++;
      fire = m_valid && m_ready;
      if (fire) begin
        fires++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("m_data", 32'(m_data), 32'(e[7:0]));
          chk("m_last", 32'(m_last), 32'(e[8]));
          chk("m_data_x", 32'(m_data_x), 32'(e[7:0] ^ (e[9] ? 8'hFF : 8'h00)));
        end else begin
          chk("unexpected_byte", 32'(m_data), 32'hFFFF_FFFF);
        end
      end
      prev_fire_last = fire && m_last;
      stalled        = m_valid && !m_ready;
      stall_data     = m_data;
      stall_last     = m_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_frame(input logic [7:0] b [$], input bit do_last, input int gap_pct);
    logic acc;
    int   budget;
    int   c;
    for (int i = 0; i < b.size(); i++) begin
      while ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = b[i];
      s_last  = do_last && (i == b.size() - 1);
      acc     = 1'b0;
      budget  = 0;
      while (!acc && budget < 1000) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
        budget++;
      end
      if (!acc) chk("accept_timeout", 32'(budget), 32'(0));
      exp_q.push_back({2'b00, b[i]});
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (do_last) begin
      c = model_crc(b);
      exp_q.push_back({2'b10, 8'(c >> 8)});
      exp_q.push_back({2'b11, 8'(c)});
      exp_crc.push_back(16'(c));
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'(0));
    chk({tag, "_crc_pending"}, 32'(exp_crc.size()), 32'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] f123 [$];
    logic [7:0] fr [$];
    int t;

    for (int v = 0; v < 256; v++) begin
      t = v << 8;
      for (int k = 0; k < 8; k++) t = (t & 'h8000) ? (((t << 1) ^ 'h1021) & 'hFFFF) : ((t << 1) & 'hFFFF);
      tbl[v] = t;
    end
    for (int i = 0; i < 9; i++) f123.push_back(8'h31 + 8'(i));

    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_m_last", 32'(m_last), 32'(0));
    chk("rst_m_data", 32'(m_data), 32'(0));
    chk("rst_crc_out", 32'(crc_out), 32'(0));
    chk("rst_crc_done", 32'(crc_done), 32'(0));
    chk("rst_s_ready", 32'(s_ready), 32'(1));
    @(posedge clk);
    #1;

    // Test 1: check string, always ready
    rdy_mode = 0; fires = 0; vcount = 0;
    send_frame(f123, 1'b1, 0);
    drain("t1");
    chk("t1_crc_out", 32'(crc_out), 32'h29B1);
    chk("t1_crc_out_x", 32'(crc_out_x), 32'hD64E);
    chk("t1_fires", 32'(fires), 32'(11));
    chk("t1_valid_cycles", 32'(vcount), 32'(11));

    // Test 2: m_ready toggling
    rdy_mode = 1; fires = 0;
    send_frame(f123, 1'b1, 0);
    drain("t2");
    chk("t2_fires", 32'(fires), 32'(11));

    // Test 3: back-to-back frames
    rdy_mode = 0; fires = 0; vcount = 0;
    send_frame(f123, 1'b1, 0);
    send_frame(f123, 1'b1, 0);
    drain("t3");
    chk("t3_fires", 32'(fires), 32'(22));
    chk("t3_valid_cycles", 32'(vcount), 32'(22));
    chk("t3_crc_out", 32'(crc_out), 32'h29B1);

    // Test 4: single-byte frame, s_ready low exactly two cycles after accept
    fires = 0;
    fr = {8'hA5};
    send_frame(fr, 1'b1, 0);
    @(negedge clk); chk("t4_s_ready_c1", 32'(s_ready), 32'(0));
    @(negedge clk); chk("t4_s_ready_c2", 32'(s_ready), 32'(0));
    @(negedge clk); chk("t4_s_ready_c3", 32'(s_ready), 32'(1));
    drain("t4");
    chk("t4_fires", 32'(fires), 32'(3));

    // Test 5: reset after the 5th byte of a frame
    fr = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    send_frame(fr, 1'b0, 0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_m_valid", 32'(m_valid), 32'(0));
    chk("t5_crc_done", 32'(crc_done), 32'(0));
    chk("t5_s_ready", 32'(s_ready), 32'(1));
    @(posedge clk);
    #1;
    fires = 0;
    send_frame(f123, 1'b1, 0);
    drain("t5");
    chk("t5_fires", 32'(fires), 32'(11));
    chk("t5_crc_out", 32'(crc_out), 32'h29B1);

    // Randomized frames with input gaps and random downstream backpressure
    rdy_mode = 2;
    for (int f = 0; f < 25; f++) begin
      fr.delete();
      for (int i = 0; i < int'($urandom_range(12, 1)); i++) fr.push_back(8'($urandom));
      send_frame(fr, 1'b1, 30);
    end
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
